// File: rtl/program_loader.sv
// Framed byte-stream loader that reassembles little-endian halfwords and
// presents them as index/data pairs on the CPU program-download port.
module program_loader #(
  parameter int         PROG_DEPTH = 256,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        download_program,
  output logic [31:0] instruction_index,
  output logic [15:0] program_in,
  output logic        busy,
  output logic        done,
  output logic        err_checksum,
  output logic        err_range
);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, HDR2, HDR3, DLO, DHI, CSUM
  } state_t;

  state_t      state;
  logic [15:0] base;
  logic [15:0] count;
  logic [15:0] hw_cnt;
  logic [7:0]  lo_byte;
  logic [7:0]  csum;

  logic        accept;
  logic [31:0] cur_idx;
  logic        idx_ok;
  logic        last_hw;

  assign in_ready = ~reset;
  assign accept   = in_valid & in_ready;
  // 32-bit sum so a base near 16'hFFFF never wraps back into range
  assign cur_idx  = {16'b0, base} + {16'b0, hw_cnt};
  assign idx_ok   = cur_idx < 32'(PROG_DEPTH);
  assign last_hw  = (hw_cnt == count - 16'd1);

  // Control: FSM, CPU-facing pair and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      hw_cnt            <= '0;
      download_program  <= 1'b0;
      instruction_index <= '0;
      program_in        <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err_checksum      <= 1'b0;
      err_range         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            if (in_data == SYNC_BYTE) begin
              state        <= HDR0;
              busy         <= 1'b1;
              err_checksum <= 1'b0;
              err_range    <= 1'b0;
            end
          end
          HDR0: state <= HDR1;
          HDR1: state <= HDR2;
          HDR2: state <= HDR3;
          HDR3: begin
            hw_cnt <= '0;
            state  <= ({in_data, count[7:0]} != 16'd0) ? DLO : CSUM;
          end
          DLO: state <= DHI;
          DHI: begin
            // index and data move together, or not at all
            if (idx_ok) begin
              instruction_index <= cur_idx;
              program_in        <= {in_data, lo_byte};
              download_program  <= 1'b1;
            end else begin
              err_range <= 1'b1;
            end
            hw_cnt <= hw_cnt + 16'd1;
            state  <= last_hw ? CSUM : DLO;
          end
          CSUM: begin
            err_checksum     <= (in_data != csum);
            download_program <= 1'b0;
            done             <= 1'b1;
            busy             <= 1'b0;
            state            <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Datapath captures: header fields, pending low byte, running checksum
  always_ff @(posedge clk) begin
    if (accept) begin
      case (state)
        IDLE: csum <= '0;
        HDR0: begin base[7:0]   <= in_data; csum <= csum ^ in_data; end
        HDR1: begin base[15:8]  <= in_data; csum <= csum ^ in_data; end
        HDR2: begin count[7:0]  <= in_data; csum <= csum ^ in_data; end
        HDR3: begin count[15:8] <= in_data; csum <= csum ^ in_data; end
        DLO:  begin lo_byte     <= in_data; csum <= csum ^ in_data; end
        DHI:  csum <= csum ^ in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: per-cycle vector table plus hand-written
// gap/resync and mid-frame reset sequences.
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        download_program;
  logic [31:0] instruction_index;
  logic [15:0] program_in;
  logic        busy;
  logic        done;
  logic        err_checksum;
  logic        err_range;

  int checks = 0;
  int errors = 0;

  program_loader #(.PROG_DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .download_program  (download_program),
    .instruction_index (instruction_index),
    .program_in        (program_in),
    .busy              (busy),
    .done              (done),
    .err_checksum      (err_checksum),
    .err_range         (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  dat;
    logic        dl;
    logic [31:0] idx;
    logic [15:0] pin;
    logic        bsy;
    logic        dne;
    logic        ec;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic rst, input logic vld, input logic [7:0] dat,
                            input logic dl, input logic [31:0] idx, input logic [15:0] pin,
                            input logic bsy, input logic dne, input logic ec, input logic er);
    vec_t t;
    t.rst = rst; t.vld = vld; t.dat = dat; t.dl = dl; t.idx = idx; t.pin = pin;
    t.bsy = bsy; t.dne = dne; t.ec = ec; t.er = er;
    vecs.push_back(t);
  endfunction

  task automatic cycle(input logic r, input logic vl, input logic [7:0] d);
    @(negedge clk);
    reset    = r;
    in_valid = vl;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, b);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {10'b0, in_ready, download_program, instruction_index, program_in,
            busy, done, err_checksum, err_range};
  endfunction

  logic [7:0] gap_frame [8];
  logic [7:0] nom_frame [12];

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset, idle junk, then the nominal frame; checksum 0A^03^20^21^05^20^60^08 = 45
    v(1,0,8'h00, 0,0,16'h0000, 0,0,0,0);
    v(1,1,8'hA5, 0,0,16'h0000, 0,0,0,0);
    v(0,0,8'h00, 0,0,16'h0000, 0,0,0,0);
    v(0,1,8'h00, 0,0,16'h0000, 0,0,0,0);
    v(0,1,8'hFF, 0,0,16'h0000, 0,0,0,0);
    v(0,1,8'hA5, 0,0,16'h0000, 1,0,0,0);
    v(0,1,8'h0A, 0,0,16'h0000, 1,0,0,0);
    v(0,1,8'h00, 0,0,16'h0000, 1,0,0,0);
    v(0,1,8'h03, 0,0,16'h0000, 1,0,0,0);
    v(0,1,8'h00, 0,0,16'h0000, 1,0,0,0);
    v(0,1,8'h20, 0,0,16'h0000, 1,0,0,0);
    v(0,1,8'h21, 1,10,16'h2120, 1,0,0,0);
    v(0,1,8'h05, 1,10,16'h2120, 1,0,0,0);
    v(0,0,8'h00, 1,10,16'h2120, 1,0,0,0);
    v(0,1,8'h20, 1,11,16'h2005, 1,0,0,0);
    v(0,1,8'h60, 1,11,16'h2005, 1,0,0,0);
    v(0,1,8'h08, 1,12,16'h0860, 1,0,0,0);
    v(0,1,8'h45, 0,12,16'h0860, 0,1,0,0);
    v(0,0,8'h00, 0,12,16'h0860, 0,0,0,0);
    // Same frame, checksum 00
    v(0,1,8'hA5, 0,12,16'h0860, 1,0,0,0);
    v(0,1,8'h0A, 0,12,16'h0860, 1,0,0,0);
    v(0,1,8'h00, 0,12,16'h0860, 1,0,0,0);
    v(0,1,8'h03, 0,12,16'h0860, 1,0,0,0);
    v(0,1,8'h00, 0,12,16'h0860, 1,0,0,0);
    v(0,1,8'h20, 0,12,16'h0860, 1,0,0,0);
    v(0,1,8'h21, 1,10,16'h2120, 1,0,0,0);
    v(0,1,8'h05, 1,10,16'h2120, 1,0,0,0);
    v(0,1,8'h20, 1,11,16'h2005, 1,0,0,0);
    v(0,1,8'h60, 1,11,16'h2005, 1,0,0,0);
    v(0,1,8'h08, 1,12,16'h0860, 1,0,0,0);
    v(0,1,8'h00, 0,12,16'h0860, 0,1,1,0);
    v(0,0,8'h00, 0,12,16'h0860, 0,0,1,0);
    v(0,1,8'h7F, 0,12,16'h0860, 0,0,1,0);
    // Range: base 15, count 2 with depth 16; checksum 0F^02^01^02 = 0E
    v(0,1,8'hA5, 0,12,16'h0860, 1,0,0,0);
    v(0,1,8'h0F, 0,12,16'h0860, 1,0,0,0);
    v(0,1,8'h00, 0,12,16'h0860, 1,0,0,0);
    v(0,1,8'h02, 0,12,16'h0860, 1,0,0,0);
    v(0,1,8'h00, 0,12,16'h0860, 1,0,0,0);
    v(0,1,8'h01, 0,12,16'h0860, 1,0,0,0);
    v(0,1,8'h00, 1,15,16'h0001, 1,0,0,0);
    v(0,1,8'h02, 1,15,16'h0001, 1,0,0,0);
    v(0,1,8'h00, 1,15,16'h0001, 1,0,0,1);
    v(0,1,8'h0E, 0,15,16'h0001, 0,1,0,1);
    v(0,0,8'h00, 0,15,16'h0001, 0,0,0,1);
    // Zero count
    v(0,1,8'hA5, 0,15,16'h0001, 1,0,0,0);
    v(0,1,8'h00, 0,15,16'h0001, 1,0,0,0);
    v(0,1,8'h00, 0,15,16'h0001, 1,0,0,0);
    v(0,1,8'h00, 0,15,16'h0001, 1,0,0,0);
    v(0,1,8'h00, 0,15,16'h0001, 1,0,0,0);
    v(0,1,8'h00, 0,15,16'h0001, 0,1,0,0);
    v(0,0,8'h00, 0,15,16'h0001, 0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].vld, vecs[i].dat);
      chk($sformatf("vec%0d", i), outs(),
          {10'b0, ~vecs[i].rst, vecs[i].dl, vecs[i].idx, vecs[i].pin,
           vecs[i].bsy, vecs[i].dne, vecs[i].ec, vecs[i].er});
    end

    // Gaps, junk and an in-frame A5 as data: base 2, count 1, data 5AA5, csum 02^01^A5^5A = FC
    gap_frame = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'hA5, 8'h5A, 8'hFC};
    send(8'h00, 2);
    send(8'hFF, 0);
    chk("junk_idle", {63'b0, busy}, 64'd0);
    for (int i = 0; i < 7; i++) begin
      send(gap_frame[i], int'($urandom_range(0, 5)));
      chk($sformatf("gap_busy%0d", i), {63'b0, busy}, 64'd1);
    end
    chk("gap_pair", {31'b0, download_program, instruction_index[15:0], program_in},
        {31'b0, 1'b1, 16'd2, 16'h5AA5});
    repeat (3) cycle(1'b0, 1'b0, 8'h00);
    chk("gap_hold", {31'b0, download_program, instruction_index[15:0], program_in},
        {31'b0, 1'b1, 16'd2, 16'h5AA5});
    send(gap_frame[7], int'($urandom_range(0, 5)));
    chk("gap_end", outs(), {10'b0, 1'b1, 1'b0, 32'd2, 16'h5AA5, 4'b0100});
    cycle(1'b0, 1'b0, 8'h00);
    chk("gap_done_clr", {63'b0, done}, 64'd0);

    // Reset while waiting for the high byte of the second halfword
    nom_frame = '{8'hA5, 8'h0A, 8'h00, 8'h03, 8'h00, 8'h20, 8'h21,
                  8'h05, 8'h20, 8'h60, 8'h08, 8'h45};
    for (int i = 0; i < 8; i++) send(nom_frame[i], 0);
    chk("pre_rst_pair", {32'b0, instruction_index[15:0], program_in}, {32'b0, 16'd10, 16'h2120});
    cycle(1'b1, 1'b1, 8'h20);
    chk("mid_rst", outs(), 64'd0);
    cycle(1'b0, 1'b1, 8'h20);
    chk("post_rst_stray", outs(), {10'b0, 1'b1, 53'd0});
    for (int i = 0; i < 12; i++) begin
      send(nom_frame[i], i % 3);
      if (i == 6)
        chk("reload_p0", {32'b0, instruction_index[15:0], program_in}, {32'b0, 16'd10, 16'h2120});
      if (i == 8)
        chk("reload_p1", {32'b0, instruction_index[15:0], program_in}, {32'b0, 16'd11, 16'h2005});
      if (i == 10)
        chk("reload_p2", {31'b0, download_program, instruction_index[15:0], program_in},
            {31'b0, 1'b1, 16'd12, 16'h0860});
    end
    chk("reload_end", outs(), {10'b0, 1'b1, 1'b0, 32'd12, 16'h0860, 4'b0100});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
